// File: rtl/fetch_decode_buffer.sv
// ---------------------------------------------------------------------------
// fetch_decode_buffer
//   Elastic FIFO between instruction fetch and decode. Holds {PC, instr}
//   pairs and pre-decodes the head entry's branch class and branch offset.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-low reset
//   in_valid      in   fetch offers an entry
//   in_ready      out  buffer can accept (count < DEPTH)
//   in_pc         in   64-bit PC of offered entry
//   in_instr      in   32-bit instruction of offered entry
//   flush         in   synchronous discard of all entries (highest priority)
//   out_valid     out  head entry valid
//   out_ready     in   decode consumes head
//   out_pc        out  head PC
//   out_instr     out  head instruction
//   out_uncond_br out  head is B
//   out_cond_br   out  head is CBZ or B.cond
//   out_br_offset out  sign-extended branch offset scaled by 4
//   count         out  occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_decode_buffer #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_pc,
    input  logic [31:0]   in_instr,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_pc,
    output logic [31:0]   out_instr,
    output logic          out_uncond_br,
    output logic          out_cond_br,
    output logic [63:0]   out_br_offset,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [63:0]   r_mem_pc    [DEPTH];
    logic [31:0]   r_mem_instr [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_count;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_enq;
    logic          w_deq;
    logic [63:0]   w_head_pc;
    logic [31:0]   w_head_instr;
    logic          w_uncond;
    logic          w_cond;
    logic [63:0]   w_offset;

    // in_ready depends only on occupancy, never on out_ready.
    assign w_in_ready  = (r_count < CW'(DEPTH));
    assign w_out_valid = (r_count != '0) && !flush;
    assign w_enq       = in_valid && w_in_ready && !flush;
    assign w_deq       = w_out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem_pc[i]    <= '0;
                r_mem_instr[i] <= '0;
            end
        end else if (flush) begin
            // Stored data is left in place; it is unreachable once count is 0.
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_mem_pc[r_wp]    <= in_pc;
                r_mem_instr[r_wp] <= in_instr;
                r_wp              <= r_wp + PW'(1);
            end
            if (w_deq) begin
                r_rp <= r_rp + PW'(1);
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + CW'(1);
            end else if (w_deq && !w_enq) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign w_head_pc    = r_mem_pc[r_rp];
    assign w_head_instr = r_mem_instr[r_rp];

    always_comb begin
        w_uncond = (w_head_instr[31:26] == 6'b000101);
        w_cond   = (w_head_instr[31:24] == 8'b10110100) ||
                   (w_head_instr[31:24] == 8'b01010100);
        w_offset = '0;
        // Sign-extend the immediate and append two zero bits (word scaling).
        if (w_uncond) begin
            w_offset = {{36{w_head_instr[25]}}, w_head_instr[25:0], 2'b00};
        end else if (w_cond) begin
            w_offset = {{43{w_head_instr[23]}}, w_head_instr[23:5], 2'b00};
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = w_out_valid;
    assign out_pc        = w_out_valid ? w_head_pc    : '0;
    assign out_instr     = w_out_valid ? w_head_instr : '0;
    assign out_uncond_br = w_out_valid && w_uncond;
    assign out_cond_br   = w_out_valid && w_cond;
    assign out_br_offset = w_out_valid ? w_offset     : '0;
    assign count         = r_count;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_buffer
//   Directed test-plan sequence followed by randomized traffic. A queue-based
//   reference model is updated on each clock edge; a negedge monitor compares
//   every DUT output against the head of that queue.
// ---------------------------------------------------------------------------
module tb_fetch_decode_buffer;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        u;
        logic        c;
        logic [63:0] off;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_pc;
    logic [31:0]   in_instr;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_uncond_br;
    logic          out_cond_br;
    logic [63:0]   out_br_offset;
    logic [CW-1:0] count;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    fetch_decode_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_uncond_br(out_uncond_br),
        .out_cond_br  (out_cond_br),
        .out_br_offset(out_br_offset),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected decode of an entry, from the architectural field definitions.
    function automatic exp_t model(input logic [63:0] pc, input logic [31:0] instr);
        exp_t e;
        logic signed [25:0] imm26;
        logic signed [18:0] imm19;
        e.pc    = pc;
        e.instr = instr;
        e.u     = (instr[31:26] == 6'h05);
        e.c     = (instr[31:24] == 8'hB4) || (instr[31:24] == 8'h54);
        imm26   = instr[25:0];
        imm19   = instr[23:5];
        if (e.u)      e.off = 64'(longint'(imm26) * 4);
        else if (e.c) e.off = 64'(longint'(imm19) * 4);
        else          e.off = 64'd0;
        return e;
    endfunction

    // Reference model: decisions use the model's own occupancy.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
        end else begin
            bit acc, dq;
            acc = in_valid && (exp_q.size() < DEPTH) && !flush;
            dq  = (exp_q.size() != 0) && out_ready && !flush;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (dq)  void'(exp_q.pop_front());
                if (acc) exp_q.push_back(model(in_pc, in_instr));
            end
        end
    end

    // Monitor: compare presented outputs against the model head.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("count", 64'(count), 64'(exp_q.size()));
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
            chk("out_valid", 64'(out_valid), 64'((exp_q.size() != 0) && !flush));
            if (exp_q.size() != 0 && !flush) begin
                chk("out_pc", out_pc, exp_q[0].pc);
                chk("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
                chk("out_uncond_br", 64'(out_uncond_br), 64'(exp_q[0].u));
                chk("out_cond_br", 64'(out_cond_br), 64'(exp_q[0].c));
                chk("out_br_offset", out_br_offset, exp_q[0].off);
            end else begin
                chk("idle_pc", out_pc, 64'd0);
                chk("idle_instr", 64'(out_instr), 64'd0);
                chk("idle_br", 64'({out_uncond_br, out_cond_br}), 64'd0);
                chk("idle_offset", out_br_offset, 64'd0);
            end
        end
    end

    // Apply inputs for one cycle; returns 1 time unit after the edge.
    task automatic drive(input logic iv, input logic [63:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        case ($urandom_range(3))
            0:       w = {6'b000101, 26'($urandom)};
            1:       w = {8'hB4, 24'($urandom)};
            2:       w = {8'h54, 24'($urandom)};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #3;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic enqueue, non-branch head.
        drive(1'b1, 64'h0, 32'h91000FE2, 1'b0, 1'b0);
        chk("t1_count", 64'(count), 64'd1);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_pc", out_pc, 64'h0);
        chk("t1_br", 64'({out_uncond_br, out_cond_br}), 64'd0);
        chk("t1_off", out_br_offset, 64'd0);
        drive(1'b1, 64'h4, 32'h14000003, 1'b0, 1'b0);
        chk("t2_full_in_ready", 64'(in_ready), 64'd0);
        chk("t2_head_held", 64'(out_instr), 64'h91000FE2);
        // Full: PC 0x8 offered but not accepted.
        drive(1'b1, 64'h8, 32'hB4FFFFC0, 1'b0, 1'b0);
        chk("t3_full_count", 64'(count), 64'd2);
        // Dequeue while full: decrement only.
        drive(1'b1, 64'h8, 32'hB4FFFFC0, 1'b1, 1'b0);
        chk("t4_count", 64'(count), 64'd1);
        chk("t4_b_instr", 64'(out_instr), 64'h14000003);
        chk("t4_b_uncond", 64'(out_uncond_br), 64'd1);
        chk("t4_b_off", out_br_offset, 64'hC);
        drive(1'b1, 64'h8, 32'hB4FFFFC0, 1'b0, 1'b0);
        chk("t5_count", 64'(count), 64'd2);
        drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        chk("t6_cbz_cond", 64'(out_cond_br), 64'd1);
        chk("t6_cbz_off", out_br_offset, 64'hFFFF_FFFF_FFFF_FFF8);
        drive(1'b1, 64'hC, 32'h54000040, 1'b1, 1'b0);
        chk("t7_count", 64'(count), 64'd1);
        chk("t7_bcond_cond", 64'(out_cond_br), 64'd1);
        chk("t7_bcond_off", out_br_offset, 64'h8);
        // Simultaneous enqueue/dequeue at count 1, pointers wrap.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h10 + 64'(4 * i), 32'hD503201F, 1'b1, 1'b0);
            chk("pass_count", 64'(count), 64'd1);
            chk("pass_pc", out_pc, 64'h10 + 64'(4 * i));
        end
        drive(1'b1, 64'h20, 32'h14000001, 1'b0, 1'b0);
        chk("pre_flush_count", 64'(count), 64'd2);
        // Flush with simultaneous enqueue offer.
        drive(1'b1, 64'h24, 32'h14000001, 1'b1, 1'b1);
        flush = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_pc", out_pc, 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(3) != 0, {32'($urandom), 32'($urandom)}, rand_instr(),
                  $urandom_range(2) != 0, $urandom_range(19) == 0);
        end

        // Asynchronous reset mid-cycle with entries present.
        drive(1'b1, 64'h100, 32'h14000002, 1'b0, 1'b0);
        drive(1'b1, 64'h104, 32'h14000002, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_pc", out_pc, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 64'h200, 32'h54000040, 1'b0, 1'b0);
        chk("post_rst_count", 64'(count), 64'd1);
        chk("post_rst_pc", out_pc, 64'h200);
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
